// File: rtl/state_seq_pkg.sv
// Shared defaults and named state encodings for the state sequencer and its control decoder.
package state_seq_pkg;

   localparam int unsigned DEF_STATE_W    = 4;
   localparam int unsigned DEF_NUM_STATES = 16;
   localparam int unsigned DEF_IDLE_STATE = 0;
   localparam int unsigned DEF_CNT_W      = 8;

   // Encodings the control decoder drives on next_state.
   typedef enum logic [DEF_STATE_W-1:0] {
      StIdle   = 4'd0,
      StFetch  = 4'd1,
      StDecode = 4'd2,
      StExec   = 4'd3,
      StMem    = 4'd4,
      StWb     = 4'd5,
      StTrap   = 4'd6,
      StWait   = 4'd7
   } seq_state_e;

endpackage

// File: rtl/state_seq_sat_counter.sv
// Saturating up-counter with synchronous clear and load; clear beats load beats increment.
module sat_counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clr,
   input  logic             i_inc,
   input  logic             i_ld,
   input  logic [WIDTH-1:0] i_ld_val,
   output logic [WIDTH-1:0] o_count,
   output logic             o_sat
);

   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] w_count_nxt;

   assign o_count = r_count;
   assign o_sat   = &r_count;

   // Next count: clear, load, or increment that sticks at all-ones.
   always_comb begin
      w_count_nxt = r_count;
      if (i_clr) begin
         w_count_nxt = '0;
      end else if (i_ld) begin
         w_count_nxt = i_ld_val;
      end else if (i_inc && !o_sat) begin
         w_count_nxt = r_count + 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else begin
         r_count <= w_count_nxt;
      end
   end

endmodule

// File: rtl/state_seq.sv
// Pipeline state sequencer: tracks present/previous state, change pulse, per-instruction
// cycle counts, completed-instruction count and a sticky illegal-state flag.
module state_seq
   import state_seq_pkg::*;
#(
   parameter int unsigned STATE_W    = DEF_STATE_W,
   parameter int unsigned NUM_STATES = DEF_NUM_STATES,
   parameter int unsigned IDLE_STATE = DEF_IDLE_STATE,
   parameter int unsigned CNT_W      = DEF_CNT_W
) (
   input  logic               multi_clk,
   input  logic               rst_n,
   input  logic [STATE_W-1:0] next_state,
   input  logic               stall,
   input  logic               flush,
   input  logic               finish,
   output logic [STATE_W-1:0] current_state,
   output logic [STATE_W-1:0] prev_state,
   output logic               state_changed,
   output logic [CNT_W-1:0]   instr_cycles,
   output logic [CNT_W-1:0]   last_instr_cycles,
   output logic [CNT_W-1:0]   instr_count,
   output logic               illegal
);

   localparam logic [STATE_W-1:0] IdleSt   = STATE_W'(IDLE_STATE);
   // One extra bit so NUM_STATES == 2**STATE_W is representable.
   localparam logic [STATE_W:0]   NumLimit = (STATE_W + 1)'(NUM_STATES);

   logic [STATE_W-1:0] r_cur_state, w_cur_state_nxt;
   logic [STATE_W-1:0] r_prev_state, w_prev_state_nxt;
   logic               r_changed, w_changed_nxt;
   logic               r_illegal, w_illegal_nxt;
   logic [CNT_W-1:0]   r_instr_count, w_instr_count_nxt;

   logic               w_cyc_clr, w_cyc_inc, w_last_ld;
   logic [CNT_W-1:0]   w_cyc_count, w_last_val;
   logic               w_cyc_sat, w_last_sat;
   logic               w_unused_sat;

   // Completed-instruction length includes the finishing cycle, held at all-ones.
   assign w_last_val   = w_cyc_sat ? w_cyc_count : w_cyc_count + 1'b1;
   assign w_unused_sat = w_last_sat;

   // Next-state decode: exactly one of flush, stall, normal applies per edge.
   always_comb begin
      w_cur_state_nxt   = r_cur_state;
      w_prev_state_nxt  = r_prev_state;
      w_illegal_nxt     = r_illegal;
      w_instr_count_nxt = r_instr_count;
      w_cyc_clr         = 1'b0;
      w_cyc_inc         = 1'b0;
      w_last_ld         = 1'b0;
      if (flush) begin
         w_cur_state_nxt  = IdleSt;
         w_prev_state_nxt = r_cur_state;
         w_cyc_clr        = 1'b1;
      end else if (stall) begin
         w_cyc_inc = 1'b1;
      end else begin
         w_prev_state_nxt = r_cur_state;
         if ({1'b0, next_state} >= NumLimit) begin
            w_cur_state_nxt = IdleSt;
            w_illegal_nxt   = 1'b1;
         end else begin
            w_cur_state_nxt = next_state;
         end
         if (finish) begin
            w_last_ld         = 1'b1;
            w_cyc_clr         = 1'b1;
            w_instr_count_nxt = r_instr_count + 1'b1;
         end else begin
            w_cyc_inc = 1'b1;
         end
      end
      w_changed_nxt = (w_cur_state_nxt != r_cur_state);
   end

   // State, change pulse, illegal flag and instruction count registers.
   always_ff @(posedge multi_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cur_state   <= IdleSt;
         r_prev_state  <= IdleSt;
         r_changed     <= 1'b0;
         r_illegal     <= 1'b0;
         r_instr_count <= '0;
      end else begin
         r_cur_state   <= w_cur_state_nxt;
         r_prev_state  <= w_prev_state_nxt;
         r_changed     <= w_changed_nxt;
         r_illegal     <= w_illegal_nxt;
         r_instr_count <= w_instr_count_nxt;
      end
   end

   sat_counter #(
      .WIDTH (CNT_W)
   ) u_cyc_cnt (
      .i_clk    (multi_clk),
      .i_rst_n  (rst_n),
      .i_clr    (w_cyc_clr),
      .i_inc    (w_cyc_inc),
      .i_ld     (1'b0),
      .i_ld_val ('0),
      .o_count  (w_cyc_count),
      .o_sat    (w_cyc_sat)
   );

   sat_counter #(
      .WIDTH (CNT_W)
   ) u_last_cnt (
      .i_clk    (multi_clk),
      .i_rst_n  (rst_n),
      .i_clr    (1'b0),
      .i_inc    (1'b0),
      .i_ld     (w_last_ld),
      .i_ld_val (w_last_val),
      .o_count  (last_instr_cycles),
      .o_sat    (w_last_sat)
   );

   assign current_state = r_cur_state;
   assign prev_state    = r_prev_state;
   assign state_changed = r_changed;
   assign illegal       = r_illegal;
   assign instr_count   = r_instr_count;
   assign instr_cycles  = w_cyc_count;

endmodule

// File: tb/tb_state_seq.sv
// Bench for state_seq: directed table, hand-written corner sequences, random run vs. model.
module tb_state_seq;

   localparam int SW   = 4;
   localparam int NS   = 10;
   localparam int CW   = 4;
   localparam int CMAX = 15;

   logic          clk;
   logic          rst_n;
   logic [SW-1:0] next_state;
   logic          stall, flush, finish;
   logic [SW-1:0] current_state, prev_state;
   logic          state_changed;
   logic [CW-1:0] instr_cycles, last_instr_cycles, instr_count;
   logic          illegal;

   int n_vec;
   int n_err;

   // Reference model state (plain integers).
   int m_cur, m_prev, m_chg, m_cyc, m_last, m_cnt, m_ill;

   state_seq #(
      .STATE_W    (SW),
      .NUM_STATES (NS),
      .IDLE_STATE (0),
      .CNT_W      (CW)
   ) dut (
      .multi_clk         (clk),
      .rst_n             (rst_n),
      .next_state        (next_state),
      .stall             (stall),
      .flush             (flush),
      .finish            (finish),
      .current_state     (current_state),
      .prev_state        (prev_state),
      .state_changed     (state_changed),
      .instr_cycles      (instr_cycles),
      .last_instr_cycles (last_instr_cycles),
      .instr_count       (instr_count),
      .illegal           (illegal)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      int ns, st, fl, fi;
      int cur, prev, chg, cyc, last, cnt;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int sat_inc(input int v);
      return (v + 1 > CMAX) ? CMAX : v + 1;
   endfunction

   task automatic model_reset();
      m_cur = 0; m_prev = 0; m_chg = 0; m_cyc = 0; m_last = 0; m_cnt = 0; m_ill = 0;
   endtask

   task automatic model_edge(input int ns, input int st, input int fl, input int fi);
      int nv;
      nv = m_cur;
      if (fl != 0) begin
         nv = 0; m_prev = m_cur; m_cyc = 0;
      end else if (st != 0) begin
         m_cyc = sat_inc(m_cyc);
      end else begin
         m_prev = m_cur;
         if (ns >= NS) begin
            nv = 0; m_ill = 1;
         end else begin
            nv = ns;
         end
         if (fi != 0) begin
            m_last = sat_inc(m_cyc); m_cyc = 0; m_cnt = (m_cnt + 1) % (CMAX + 1);
         end else begin
            m_cyc = sat_inc(m_cyc);
         end
      end
      m_chg = (nv != m_cur) ? 1 : 0;
      m_cur = nv;
   endtask

   task automatic check_model(input string tag);
      chk({tag, " cur"},     current_state,     m_cur);
      chk({tag, " prev"},    prev_state,        m_prev);
      chk({tag, " changed"}, state_changed,     m_chg);
      chk({tag, " cycles"},  instr_cycles,      m_cyc);
      chk({tag, " last"},    last_instr_cycles, m_last);
      chk({tag, " count"},   instr_count,       m_cnt);
      chk({tag, " illegal"}, illegal,           m_ill);
   endtask

   // Drive inputs, take one edge, advance the model, settle 1 time unit past the edge.
   task automatic step(input int ns, input int st, input int fl, input int fi);
      next_state = SW'(ns);
      stall      = st[0];
      flush      = fl[0];
      finish     = fi[0];
      @(posedge clk);
      model_edge(ns, st, fl, fi);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      model_reset();
      check_model("reset");
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b1;
      next_state = '0; stall = 1'b0; flush = 1'b0; finish = 1'b0;
      model_reset();
      #1;

      //                ns st fl fi  cur prev chg cyc last cnt
      tbl[0] = '{1, 0, 0, 0,  1, 0, 1, 1, 0, 0};
      tbl[1] = '{2, 0, 0, 0,  2, 1, 1, 2, 0, 0};
      tbl[2] = '{3, 0, 0, 1,  3, 2, 1, 0, 3, 1};
      tbl[3] = '{5, 1, 0, 0,  3, 2, 0, 1, 3, 1};
      tbl[4] = '{5, 1, 0, 1,  3, 2, 0, 2, 3, 1};
      tbl[5] = '{5, 0, 0, 0,  5, 3, 1, 3, 3, 1};
      tbl[6] = '{5, 0, 0, 0,  5, 5, 0, 4, 3, 1};
      tbl[7] = '{7, 0, 1, 1,  0, 5, 1, 0, 3, 1};
      tbl[8] = '{0, 0, 1, 0,  0, 0, 0, 0, 3, 1};
      tbl[9] = '{0, 0, 0, 1,  0, 0, 0, 0, 1, 2};

      do_reset();
      for (int i = 0; i < 10; i++) begin
         step(tbl[i].ns, tbl[i].st, tbl[i].fl, tbl[i].fi);
         chk($sformatf("tbl%0d cur", i),     current_state,     tbl[i].cur);
         chk($sformatf("tbl%0d prev", i),    prev_state,        tbl[i].prev);
         chk($sformatf("tbl%0d changed", i), state_changed,     tbl[i].chg);
         chk($sformatf("tbl%0d cycles", i),  instr_cycles,      tbl[i].cyc);
         chk($sformatf("tbl%0d last", i),    last_instr_cycles, tbl[i].last);
         chk($sformatf("tbl%0d count", i),   instr_count,       tbl[i].cnt);
         chk($sformatf("tbl%0d illegal", i), illegal,           0);
      end

      // Illegal request recovers to idle and the flag sticks across legal states.
      do_reset();
      step(3, 0, 0, 0);
      step(12, 0, 0, 0);
      chk("ill cur", current_state, 0);
      chk("ill prev", prev_state, 3);
      chk("ill flag", illegal, 1);
      chk("ill changed", state_changed, 1);
      step(4, 0, 0, 0);
      step(9, 0, 0, 0);
      chk("ill sticky cur", current_state, 9);
      chk("ill sticky flag", illegal, 1);

      // Cycle counter saturation and instruction count wrap.
      do_reset();
      for (int i = 0; i < 20; i++) step(1, 0, 0, 0);
      chk("sat cycles", instr_cycles, 15);
      step(1, 0, 0, 1);
      chk("sat last", last_instr_cycles, 15);
      chk("sat cycles clr", instr_cycles, 0);
      chk("sat count1", instr_count, 1);
      for (int i = 0; i < 16; i++) step(2, 0, 0, 1);
      chk("wrap count", instr_count, 1);
      chk("wrap last", last_instr_cycles, 1);

      // Asynchronous reset between edges mid-instruction, then a normal first edge.
      step(6, 0, 0, 0);
      step(7, 0, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_model("async");
      #1;
      rst_n = 1'b1;
      step(4, 0, 0, 0);
      chk("post-reset cur", current_state, 4);
      chk("post-reset changed", state_changed, 1);
      chk("post-reset cycles", instr_cycles, 1);

      // Randomized run against the model, with occasional resets.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(63) == 0) begin
            do_reset();
         end else begin
            step($urandom_range(15), ($urandom_range(3) == 0) ? 1 : 0,
                 ($urandom_range(7) == 0) ? 1 : 0, ($urandom_range(3) == 0) ? 1 : 0);
            check_model($sformatf("rnd%0d", i));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
